// File: rtl/parking_pkg.sv
// parking_pkg: shared state encoding and default keypad settings for the parking entry controller
package parking_pkg;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_PIN  = 2'd1,
        GATE_OPEN = 2'd2,
        BLOCKED   = 2'd3
    } state_t;
    localparam int          CODE_W_DEF   = 16;
    localparam logic [15:0] PASSWORD_DEF = 16'h5990;
endpackage

// File: rtl/parking_occ_counter.sv
// parking_occ_counter: saturating up/down occupancy counter with registered full flag
module parking_occ_counter #(
    parameter  int CAPACITY = 8,
    localparam int OCC_W    = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [OCC_W-1:0] occupancy,
    output logic             full
);
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             full_q, full_d;

    // Simultaneous entry and exit cancel out
    always_comb begin
        occ_d  = (inc && !dec && occ_q != OCC_W'(CAPACITY)) ? occ_q + 1'b1 :
                 (dec && !inc && occ_q != '0)               ? occ_q - 1'b1 : occ_q;
        full_d = occ_d == OCC_W'(CAPACITY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= '0;
            full_q <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            full_q <= full_d;
        end
    end

    assign occupancy = occ_q;
    assign full      = full_q;
endmodule

// File: rtl/parking_gate_ctrl_multi.sv
// parking_gate_ctrl_multi: PIN-checked entry gate with lot-full gating, wrong-PIN limit and tailgate alarm
module parking_gate_ctrl_multi
    import parking_pkg::*;
#(
    parameter  int                CODE_W       = CODE_W_DEF,
    parameter  logic [CODE_W-1:0] PASSWORD     = CODE_W'(PASSWORD_DEF),
    parameter  int                MAX_ATTEMPTS = 3,
    parameter  int                CAPACITY     = 8,
    localparam int                OCC_W        = $clog2(CAPACITY + 1),
    localparam int                ATT_W        = $clog2(MAX_ATTEMPTS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vehicle_arrival,
    input  logic              vehicle_left,
    input  logic              vehicle_exit,
    input  logic [CODE_W-1:0] code,
    input  logic              code_ack,
    output logic              gate_open,
    output logic              gate_closed,
    output logic              wrong_pin_alarm,
    output logic              block_alarm,
    output logic              lot_full,
    output logic [OCC_W-1:0]  occupancy,
    output logic [ATT_W-1:0]  attempt_cnt
);
    state_t           state_q, state_d;
    logic [ATT_W-1:0] att_q, att_d;
    logic             ack_q, ack_d, ack_rise, pin_ok, occ_inc;
    logic             gate_open_q, gate_open_d, block_q, block_d, wrong_q, wrong_d;

    assign ack_rise = code_ack && !ack_q;
    assign pin_ok   = ack_rise && code == PASSWORD;

    always_comb begin
        state_d = state_q;
        att_d   = att_q;
        ack_d   = code_ack;
        occ_inc = 1'b0;
        case (state_q)
            IDLE: if (vehicle_arrival && !lot_full) state_d = WAIT_PIN;
            WAIT_PIN: begin
                if (!vehicle_arrival) begin
                    state_d = IDLE;
                    att_d   = '0;
                end else if (pin_ok) begin
                    state_d = GATE_OPEN;
                    att_d   = '0;
                end else if (ack_rise) begin
                    att_d = att_q + 1'b1;
                    if (att_d == ATT_W'(MAX_ATTEMPTS)) state_d = BLOCKED;
                end
            end
            GATE_OPEN: if (vehicle_left) begin
                occ_inc = 1'b1;
                state_d = vehicle_arrival ? BLOCKED : IDLE;
            end
            BLOCKED: if (pin_ok) begin
                state_d = IDLE;
                att_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        gate_open_d = state_d == GATE_OPEN;
        block_d     = state_d == BLOCKED;
        wrong_d     = state_d == WAIT_PIN && att_d != '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            att_q       <= '0;
            ack_q       <= 1'b0;
            gate_open_q <= 1'b0;
            block_q     <= 1'b0;
            wrong_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            att_q       <= att_d;
            ack_q       <= ack_d;
            gate_open_q <= gate_open_d;
            block_q     <= block_d;
            wrong_q     <= wrong_d;
        end
    end

    parking_occ_counter #(.CAPACITY(CAPACITY)) u_occ (
        .clk       (clk),
        .rst       (rst),
        .inc       (occ_inc),
        .dec       (vehicle_exit),
        .occupancy (occupancy),
        .full      (lot_full)
    );

    assign gate_open       = gate_open_q;
    assign gate_closed     = !gate_open_q;
    assign wrong_pin_alarm = wrong_q;
    assign block_alarm     = block_q;
    assign attempt_cnt     = att_q;
endmodule

// File: tb/tb_parking_gate_ctrl_multi.sv
// tb_parking_gate_ctrl_multi: directed scenarios plus random traffic against a behavioural gate model
module tb_parking_gate_ctrl_multi;
    localparam int          CAP = 2;
    localparam int          MAX = 3;
    localparam logic [15:0] PW  = 16'h5990;

    logic        clk = 0, rst = 0;
    logic        arr = 0, left = 0, ext = 0, ack = 0;
    logic [15:0] code = '0;
    logic        gate_open, gate_closed, wrong_pin_alarm, block_alarm, lot_full;
    logic [1:0]  occupancy, attempt_cnt;

    int checks = 0, errors = 0;

    // Model: car waiting for PIN, gate raised, lane locked, wrong tries, cars parked
    bit m_wait, m_open, m_lock, m_prev_ack;
    int m_tries, m_cars;

    parking_gate_ctrl_multi #(.MAX_ATTEMPTS(MAX), .CAPACITY(CAP)) dut (
        .clk(clk), .rst(rst), .vehicle_arrival(arr), .vehicle_left(left), .vehicle_exit(ext),
        .code(code), .code_ack(ack), .gate_open(gate_open), .gate_closed(gate_closed),
        .wrong_pin_alarm(wrong_pin_alarm), .block_alarm(block_alarm), .lot_full(lot_full),
        .occupancy(occupancy), .attempt_cnt(attempt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit rise, good, entered;
        rise = ack && !m_prev_ack;
        good = rise && code == PW;
        entered = 0;
        if (rst) begin
            m_wait = 0; m_open = 0; m_lock = 0; m_tries = 0; m_cars = 0; m_prev_ack = 0;
            return;
        end
        if (m_lock) begin
            if (good) begin m_lock = 0; m_tries = 0; end
        end else if (m_open) begin
            if (left) begin entered = 1; m_open = 0; m_lock = arr; end
        end else if (m_wait) begin
            if (!arr) begin m_wait = 0; m_tries = 0; end
            else if (good) begin m_wait = 0; m_open = 1; m_tries = 0; end
            else if (rise) begin
                m_tries++;
                if (m_tries == MAX) begin m_wait = 0; m_lock = 1; end
            end
        end else if (arr && m_cars < CAP) m_wait = 1;
        if (entered && !ext && m_cars < CAP) m_cars++;
        if (ext && !entered && m_cars > 0) m_cars--;
        m_prev_ack = ack;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("gate_open", gate_open, m_open);
        chk("gate_closed", gate_closed, !m_open);
        chk("block_alarm", block_alarm, m_lock);
        chk("wrong_pin_alarm", wrong_pin_alarm, m_wait && m_tries > 0);
        chk("lot_full", lot_full, m_cars == CAP);
        chk("occupancy", occupancy, m_cars);
        chk("attempt_cnt", attempt_cnt, m_tries);
    endtask

    task automatic submit(input logic [15:0] c);
        code = c; ack = 1; step();
        ack = 0; step();
    endtask

    initial begin
        rst = 1; step(); step();
        chk("rst_gate_closed", gate_closed, 1);
        chk("rst_occ", occupancy, 0);
        rst = 0;
        // 1 normal entry
        arr = 1; step();
        code = PW; ack = 1; step();
        chk("t1_open", gate_open, 1);
        ack = 0; left = 1; arr = 0; step();
        chk("t1_occ", occupancy, 1);
        chk("t1_closed", gate_closed, 1);
        left = 0; step();
        // 2 two wrong PINs then give up
        arr = 1; step();
        submit(16'h1234); submit(16'h3145);
        chk("t2_att", attempt_cnt, 2);
        chk("t2_alarm", wrong_pin_alarm, 1);
        arr = 0; step();
        chk("t2_att_clr", attempt_cnt, 0);
        chk("t2_noblock", block_alarm, 0);
        // 3 lockout, extra wrong PIN frozen, correct PIN releases
        arr = 1; step();
        submit(16'h1111); submit(16'h2222); submit(16'h3333);
        chk("t3_block", block_alarm, 1);
        submit(16'h4444);
        chk("t3_frozen", attempt_cnt, 3);
        arr = 0; code = PW; ack = 1; step();
        chk("t3_release", block_alarm, 0);
        ack = 0; step();
        // 4 tailgate
        arr = 1; step();
        code = PW; ack = 1; step();
        ack = 0; left = 1; step();
        chk("t4_block", block_alarm, 1);
        chk("t4_occ", occupancy, 2);
        left = 0; arr = 0; submit(PW);
        // 5 lot full, exit frees space, entry+exit cancel
        chk("t5_full", lot_full, 1);
        arr = 1; step(); step();
        chk("t5_held", gate_open, 0);
        chk("t5_nowait", wrong_pin_alarm, 0);
        ext = 1; step();
        ext = 0;
        chk("t5_occ_dec", occupancy, 1);
        chk("t5_not_full", lot_full, 0);
        step();
        code = PW; ack = 1; step();
        ack = 0; left = 1; arr = 0; ext = 1; step();
        chk("t5_cancel", occupancy, 1);
        left = 0; ext = 0; step();
        // 6 held ack counts once, then reset mid-entry
        arr = 1; step();
        code = 16'hbeef; ack = 1;
        repeat (50) step();
        chk("t6_once", attempt_cnt, 1);
        ack = 0; arr = 0; step();
        arr = 1; step();
        code = PW; ack = 1; step();
        chk("t6_open", gate_open, 1);
        ack = 0; rst = 1; step();
        chk("t6_rst_closed", gate_closed, 1);
        chk("t6_rst_occ", occupancy, 0);
        rst = 0;
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(299) == 0);
            arr  = ($urandom_range(3) != 0);
            left = ($urandom_range(3) == 0);
            ext  = ($urandom_range(7) == 0);
            ack  = $urandom_range(1);
            code = ($urandom_range(2) == 0) ? PW : 16'($urandom);
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
